// File: rtl/shift_unit_pkg.sv
// Shared encodings for the iterative shifter and its per-cycle shift step.
// Mode and FSM state constants only; no logic.
// Imported by shift_step and shift_unit_iter.
package shift_unit_pkg;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Shifts acc by step positions in one of four modes (SLL/SRL/SRA/ROL).
// Purely combinational, zero latency.
// No handshake; the caller sequences it.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [SHAMT_W-1:0] step,
    input  logic [1:0]         mode,
    output logic [WIDTH-1:0]   next_acc
);

    logic signed [WIDTH-1:0] acc_s;
    logic [2*WIDTH-1:0]      rot_wide;

    always_comb begin
        acc_s    = acc;
        // Doubling the operand turns a rotate into a plain shift of the upper half.
        rot_wide = {acc, acc} << step;
        next_acc = acc;
        case (mode)
            MODE_SLL: next_acc = acc << step;
            MODE_SRL: next_acc = acc >> step;
            MODE_SRA: next_acc = $unsigned(acc_s >>> step);
            MODE_ROL: next_acc = rot_wide[2*WIDTH-1:WIDTH];
            default:  next_acc = acc;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// Iterative multi-mode shifter, at most MAX_STEP bit positions per cycle.
// Latency: 1 + ceil(shamt / MAX_STEP) cycles from accept to out_valid.
// One request in flight; in_ready low until the result is taken, out_data held under backpressure.
module shift_unit_iter
    import shift_unit_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int MAX_STEP = 4,
    localparam int SHAMT_W  = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam logic [SHAMT_W-1:0] MAX_STEP_W = SHAMT_W'(MAX_STEP);

    logic [1:0]         state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [1:0]         mode_q;
    logic [SHAMT_W-1:0] step;
    logic [WIDTH-1:0]   next_acc;

    assign step      = (rem_q < MAX_STEP_W) ? rem_q : MAX_STEP_W;
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .acc      (acc_q),
        .step     (step),
        .mode     (mode_q),
        .next_acc (next_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= MODE_SLL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_q   <= in_data;
                        rem_q   <= in_shamt;
                        mode_q  <= in_mode;
                        state_q <= (in_shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= next_acc;
                    rem_q <= rem_q - step;
                    // step == rem_q means this is the final chunk.
                    if (rem_q == step) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed-vector bench for shift_unit_iter with hand-computed results and latencies.
// Covers all modes, shamt 0 and 31, backpressure and mid-operation reset.
module tb_shift_unit_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_chk  = 0;
    int n_pass = 0;

    shift_unit_iter #(
        .WIDTH    (32),
        .MAX_STEP (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Present a request at a falling edge and hold it until accepted.
    task automatic issue(input logic [1:0] m, input logic [31:0] d, input logic [4:0] s);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_shamt = s;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called #1 after the accept edge; returns cycles until out_valid (bounded).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] d,
                          input logic [4:0] s, input logic [31:0] exp_d, input int exp_lat);
        int lat;
        issue(m, d, s);
        wait_done(lat);
        check({tag, "_lat"},  lat, exp_lat);
        check({tag, "_data"}, out_data, exp_d);
        consume(tag);
    endtask

    initial begin
        int lat;
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hA5A5_A5A5;
        in_shamt  = 5'd3;
        in_mode   = 2'b00;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ignores_inputs", {31'd0, out_valid}, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b0;

        run_op("sll_1_2",     2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 2);
        run_op("sra_31",      2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
        run_op("srl_31",      2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9);
        run_op("rol_4",       2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018, 2);
        run_op("srl_7",       2'b01, 32'hF000_0000, 5'd7,  32'h01E0_0000, 3);
        run_op("srl_0",       2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
        run_op("sll_5",       2'b00, 32'h0000_00FF, 5'd5,  32'h0000_1FE0, 3);
        run_op("rol_8",       2'b11, 32'h1234_5678, 5'd8,  32'h3456_7812, 3);
        run_op("sra_pos_3",   2'b10, 32'h7000_0000, 5'd3,  32'h0E00_0000, 2);

        // Backpressure: result held while a second request waits.
        issue(2'b00, 32'h1234_5678, 5'd4);
        wait_done(lat);
        check("bp_lat", lat, 2);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = 2'b10;
        in_data  = 32'h8000_0010;
        in_shamt = 5'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data",  out_data, 32'h2345_6780);
            check("bp_in_ready",  {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
        wait_done(lat);
        check("bp_second_lat",  lat, 2);
        check("bp_second_data", out_data, 32'hF800_0001);
        consume("bp_second");

        // Reset in the second SHIFT cycle aborts the operation.
        issue(2'b01, 32'hFFFF_0000, 5'd20);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data",  out_data, 32'd0);
        check("arst_in_ready",  {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("arst_no_result", seen, 0);
        check("arst_idle", {31'd0, in_ready}, 32'd1);
        run_op("post_rst_srl_20", 2'b01, 32'hFFFF_0000, 5'd20, 32'h0000_0FFF, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
